// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell plus a borrow flop walks through the operands.
// Operands arrive on a valid/ready handshake and the result leaves on a second one.
module serial_subtractor #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         bout,
    output logic         zero
);

    // Wide enough to hold W, so the counter never wraps during an operation.
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [W-1:0]  a_sh_reg, a_sh_next;
    logic [W-1:0]  b_sh_reg, b_sh_next;
    logic [W-1:0]  res_reg, res_next;
    logic          brw_reg, brw_next;
    logic          bout_reg, bout_next;
    logic          zero_reg, zero_next;
    logic [CW-1:0] cnt_reg, cnt_next;

    logic          x_bit, y_bit, d_bit, brw_new;
    logic [W-1:0]  res_shifted;

    // Full-subtractor cell on the current LSBs, and the result with the new bit
    // shifted in at the MSB.
    always_comb begin
        x_bit       = a_sh_reg[0];
        y_bit       = b_sh_reg[0];
        d_bit       = x_bit ^ y_bit ^ brw_reg;
        brw_new     = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & brw_reg);
        // The shift form works for W=1 too, where the result is just the new bit.
        res_shifted = (res_reg >> 1) | (W'(d_bit) << (W - 1));
    end

    // Next-state and datapath control for the IDLE/SHIFT/DONE sequence.
    always_comb begin
        state_next = state_reg;
        a_sh_next  = a_sh_reg;
        b_sh_next  = b_sh_reg;
        res_next   = res_reg;
        brw_next   = brw_reg;
        bout_next  = bout_reg;
        zero_next  = zero_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    a_sh_next  = a;
                    b_sh_next  = b;
                    brw_next   = bin;
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                a_sh_next = a_sh_reg >> 1;
                b_sh_next = b_sh_reg >> 1;
                res_next  = res_shifted;
                brw_next  = brw_new;
                cnt_next  = cnt_reg + CW'(1);
                if (cnt_reg == CW'(W - 1)) begin
                    // Last bit: freeze the flags alongside the final result.
                    bout_next  = brw_new;
                    zero_next  = (res_shifted == '0);
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            res_reg   <= '0;
            brw_reg   <= 1'b0;
            bout_reg  <= 1'b0;
            zero_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            a_sh_reg  <= a_sh_next;
            b_sh_reg  <= b_sh_next;
            res_reg   <= res_next;
            brw_reg   <= brw_next;
            bout_reg  <= bout_next;
            zero_reg  <= zero_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Handshake flags are pure decodes of the registered state.
    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign diff      = res_reg;
    assign bout      = bout_reg;
    assign zero      = zero_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vector table, backpressure,
// mid-operation reset, back-to-back random stream (W=8) and exhaustive W=1.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, diff8;
    logic       bin8 = 1'b0, bout8, zero8;

    logic       in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0, diff1;
    logic       bin1 = 1'b0, bout1, zero1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.W(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .bin(bin8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .diff(diff8), .bout(bout8), .zero(zero8)
    );

    serial_subtractor #(.W(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .bin(bin1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .diff(diff1), .bout(bout1), .zero(zero1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bo;
        logic       z;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One W=8 operation, optionally holding out_ready low for 'hold' cycles in DONE
    // while pulsing in_valid with junk operands that must be ignored.
    task automatic do_op8(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                          input logic ibin, input logic [7:0] ed, input logic ebo,
                          input logic ez, input int hold);
        int n;
        n = 0;
        while (!in_ready8 && n < 50) begin @(negedge clk); n++; end
        check({tag, " in_ready"}, 32'(in_ready8), 32'd1);
        a8 = ia; b8 = ib; bin8 = ibin; in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        n = 0;
        while (!out_valid8 && n < 50) begin @(negedge clk); n++; end
        check({tag, " latency"}, 32'(n), 32'd8);
        check({tag, " diff"}, 32'(diff8), 32'(ed));
        check({tag, " bout"}, 32'(bout8), 32'(ebo));
        check({tag, " zero"}, 32'(zero8), 32'(ez));
        for (int i = 0; i < hold; i++) begin
            in_valid8 = i[0] ? 1'b0 : 1'b1;
            a8 = 8'(i * 37); b8 = 8'(i * 11); bin8 = i[1];
            @(negedge clk);
            check({tag, " hold out_valid"}, 32'(out_valid8), 32'd1);
            check({tag, " hold in_ready"}, 32'(in_ready8), 32'd0);
            check({tag, " hold result"}, {23'd0, bout8, zero8, diff8}, {23'd0, ebo, ez, ed});
        end
        in_valid8 = 1'b0;
        $display("op %s: a=%h b=%h bin=%b -> diff=%h bout=%b zero=%b", tag, ia, ib, ibin,
                 diff8, bout8, zero8);
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        check({tag, " out_valid drop"}, 32'(out_valid8), 32'd0);
        check({tag, " back to idle"}, 32'(in_ready8), 32'd1);
    endtask

    task automatic do_op1(input logic ia, input logic ib, input logic ibin);
        int n;
        logic [1:0] m;
        m = {1'b0, ia} - {1'b0, ib} - {1'b0, ibin};
        n = 0;
        while (!in_ready1 && n < 20) begin @(negedge clk); n++; end
        a1 = ia; b1 = ib; bin1 = ibin; in_valid1 = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b0;
        n = 0;
        while (!out_valid1 && n < 20) begin @(negedge clk); n++; end
        check("w1 latency", 32'(n), 32'd1);
        check("w1 result", {29'd0, bout1, zero1, diff1}, {29'd0, m[1], ~m[0], m[0]});
        $display("w1 op: a=%b b=%b bin=%b -> diff=%b bout=%b zero=%b", ia, ib, ibin,
                 diff1, bout1, zero1);
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
        check("w1 idle", 32'(in_ready1), 32'd1);
    endtask

    initial begin
        logic [8:0] m9;
        logic [9:0] exq[$];
        logic [9:0] e;
        int n, sent, got, cyc, last;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[5] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0};
        vecs[6] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[7] = '{8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset in_ready", 32'(in_ready8), 32'd1);
        check("reset out_valid", 32'(out_valid8), 32'd0);
        check("reset outputs", {22'd0, bout8, zero8, diff8}, 32'd0);

        // Directed vector table
        for (int i = 0; i < 8; i++)
            do_op8($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin,
                   vecs[i].d, vecs[i].bo, vecs[i].z, 0);

        // Backpressure in DONE for 5 cycles with ignored in_valid pulses
        do_op8("bp", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, 5);
        @(negedge clk);
        check("bp no capture", 32'(in_ready8), 32'd1);

        // Reset after the third SHIFT cycle
        a8 = 8'hFF; b8 = 8'h01; bin8 = 1'b0; in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        repeat (3) @(negedge clk);
        check("pre-reset busy", 32'(in_ready8), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid reset in_ready", 32'(in_ready8), 32'd1);
        check("mid reset out_valid", 32'(out_valid8), 32'd0);
        check("mid reset diff", 32'(diff8), 32'd0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid8) n++;
        end
        check("mid reset no result", 32'(n), 32'd0);
        do_op8("after reset", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 0);

        // Back-to-back random stream with in_valid and out_ready held high
        sent = 0; got = 0; cyc = 0; last = -1;
        out_ready8 = 1'b1;
        while (got < 1000 && cyc < 20000) begin
            if (out_valid8) begin
                e = exq.pop_front();
                check("rand result", {22'd0, bout8, zero8, diff8}, {22'd0, e});
                if (last >= 0) check("rand interval", 32'(cyc - last), 32'd10);
                $display("rand %0d: diff=%h bout=%b zero=%b", got, diff8, bout8, zero8);
                last = cyc;
                got++;
            end
            if (in_ready8) begin
                if (sent < 1000) begin
                    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
                    m9 = {1'b0, a8} - {1'b0, b8} - {8'd0, bin8};
                    exq.push_back({m9[8], (m9[7:0] == 8'd0), m9[7:0]});
                    in_valid8 = 1'b1;
                    sent++;
                end else begin
                    in_valid8 = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        check("rand count", 32'(got), 32'd1000);
        in_valid8 = 1'b0;
        out_ready8 = 1'b0;

        // W=1 exhaustive
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            do_op1(v[2], v[1], v[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
